// File: rtl/task_input_pkg.sv
// Shared types for the task input packet buffer: FSM state encoding and
// the width of one stored FIFO entry {last, data}.
package task_input_pkg;

    typedef enum logic [1:0] {
        s_IDLE    = 2'd0,
        s_LOAD    = 2'd1,
        s_DISCARD = 2'd2,
        s_SEND    = 2'd3
    } state_t;

    // A stored entry is the data word plus its end-of-packet flag in the MSB.
    function automatic int entry_w(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/task_input_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is presented on
// dout combinationally; rd_en pops it. Writes into a full FIFO and reads from
// an empty FIFO are ignored.
module task_input_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             din,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Storage array write.
    // NOTE: the data array has no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy count; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                count <= count + 1'b1;
            end else if (do_rd && !do_wr) begin
                count <= count - 1'b1;
            end
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/task_input_pkt_buffer.sv
// Store-and-forward packet buffer for the task input path. Captures one
// packet into the FIFO (truncating it at DEPTH words and dropping the rest),
// then replays it downstream with valid/ready and an end-of-packet marker.
module task_input_pkt_buffer
    import task_input_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_tvalid,
    input  logic [DATA_W-1:0] i_tdata,
    input  logic              i_tlast,
    output logic              o_tready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_last,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count,
    output logic [CNT_W-1:0]  o_pkt_len,
    output logic              o_overflow
);

    localparam int ENTRY_W = entry_w(DATA_W);

    state_t             state_q;
    state_t             state_d;
    logic               in_xfer;
    logic               out_xfer;
    logic               fill_trunc;
    logic               wr_en;
    logic               wr_last;
    logic [ENTRY_W-1:0] fifo_dout;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;

    task_input_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .wr_en (wr_en),
        .din   ({wr_last, i_tdata}),
        .rd_en (out_xfer),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_xfer  = i_tvalid && o_tready;
    assign out_xfer = o_valid && i_ready;

    // A non-final word landing in the last free slot ends the stored packet.
    assign fill_trunc = in_xfer && (state_q == s_LOAD) && !i_tlast
                        && (fifo_count == CNT_W'(DEPTH - 1));
    assign wr_en      = in_xfer && (state_q == s_LOAD);
    assign wr_last    = i_tlast || fill_trunc;

    assign o_data  = fifo_dout[DATA_W-1:0];
    assign o_last  = o_valid && fifo_dout[DATA_W];
    assign o_empty = fifo_empty;
    assign o_count = fifo_count;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= s_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // NOTE: state_d gets a default first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            s_IDLE: begin
                state_d = s_LOAD;
            end
            s_LOAD: begin
                if (in_xfer && i_tlast) begin
                    state_d = s_SEND;
                end else if (fill_trunc) begin
                    state_d = s_DISCARD;
                end
            end
            s_DISCARD: begin
                if (in_xfer && i_tlast) begin
                    state_d = s_SEND;
                end
            end
            s_SEND: begin
                if (out_xfer && o_last) begin
                    state_d = s_IDLE;
                end
            end
            default: begin
                state_d = s_IDLE;
            end
        endcase
    end

    // Handshake and status outputs, decoded from the registered state only.
    always_comb begin
        o_tready = 1'b0;
        o_valid  = 1'b0;
        o_busy   = 1'b0;
        case (state_q)
            s_LOAD: begin
                o_tready = 1'b1;
            end
            s_DISCARD: begin
                o_tready = 1'b1;
                o_busy   = 1'b1;
            end
            s_SEND: begin
                o_valid = !fifo_empty;
                o_busy  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Packet length snapshot on entry to s_SEND and sticky truncation flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pkt_len  <= '0;
            o_overflow <= 1'b0;
        end else begin
            if ((state_q != s_SEND) && (state_d == s_SEND)) begin
                // From s_LOAD the final word is being written this cycle.
                o_pkt_len <= (state_q == s_LOAD) ? fifo_count + 1'b1 : fifo_count;
            end
            if (fill_trunc) begin
                o_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_task_input_pkt_buffer.sv
// Self-checking bench for task_input_pkt_buffer: directed table of packets,
// reset corner sequences, then randomized packets against a packet-level model.
module tb_task_input_pkt_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int BUDGET = 2000;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_tvalid = 1'b0;
    logic [DATA_W-1:0] i_tdata = '0;
    logic              i_tlast = 1'b0;
    logic              o_tready;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_last;
    logic              i_ready = 1'b0;
    logic              o_busy;
    logic              o_empty;
    logic [CNT_W-1:0]  o_count;
    logic [CNT_W-1:0]  o_pkt_len;
    logic              o_overflow;

    int n_pass  = 0;
    int n_total = 0;
    bit model_ovf = 1'b0;

    task_input_pkt_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_tvalid   (i_tvalid),
        .i_tdata    (i_tdata),
        .i_tlast    (i_tlast),
        .o_tready   (o_tready),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_last     (o_last),
        .i_ready    (i_ready),
        .o_busy     (o_busy),
        .o_empty    (o_empty),
        .o_count    (o_count),
        .o_pkt_len  (o_pkt_len),
        .o_overflow (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Drive one packet and collect the replay. Entered and left at posedge+1.
    // ready_mode: 0 = always ready, 1 = random, 2 = pattern 1,0,0,1,0,1.
    task automatic run_packet(input string tag, input int len, input logic [7:0] base,
                              input bit rnd_data, input int ready_mode, input bit rnd_valid,
                              output int n_got, output logic [7:0] last_data);
        logic [7:0] words[$];
        logic [8:0] got[$];
        logic [8:0] prev_out = '0;
        bit         prev_hold = 1'b0;
        bit         done = 1'b0;
        int         idx = 0;
        int         cyc = 0;
        int         tlast_cyc = -1;
        int         first_v_cyc = -1;
        int         last_xfer_cyc = -1;
        int         rdy_idx = 0;
        int         max_cnt = 0;
        int         n_exp;
        bit         pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        for (int i = 0; i < len; i++) begin
            words.push_back(rnd_data ? 8'($urandom) : 8'(base + i));
        end
        // Packet-level model: keep at most DEPTH words, last flag on the final kept word.
        n_exp = (len > DEPTH) ? DEPTH : len;
        if (len > DEPTH) model_ovf = 1'b1;

        while (!done && cyc < BUDGET) begin
            i_tvalid = (idx < len) && (!rnd_valid || $urandom_range(3) != 0);
            i_tdata  = (idx < len) ? words[idx] : 8'($urandom);
            i_tlast  = (idx == len - 1);
            case (ready_mode)
                0:       i_ready = 1'b1;
                1:       i_ready = ($urandom_range(4) < 3);
                default: i_ready = o_valid ? pat[rdy_idx % 6] : 1'b1;
            endcase
            @(negedge i_clk);
            if (int'(o_count) > max_cnt) max_cnt = int'(o_count);
            if (prev_hold) begin
                check({tag, " hold"}, 32'({o_valid, o_last, o_data}), 32'({1'b1, prev_out}));
            end
            if (o_valid && first_v_cyc < 0) begin
                first_v_cyc = cyc;
                check({tag, " busy"}, 32'(o_busy), 32'd1);
            end
            if (o_tready && i_tvalid) begin
                if (i_tlast) tlast_cyc = cyc;
                idx++;
            end
            if (o_valid && i_ready) begin
                got.push_back({o_last, o_data});
                if (o_last) begin
                    done = 1'b1;
                    last_xfer_cyc = cyc;
                end
            end
            prev_hold = o_valid && !i_ready;
            prev_out  = {o_last, o_data};
            if (ready_mode == 2 && o_valid) rdy_idx++;
            step();
            cyc++;
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        i_ready  = 1'b0;

        check({tag, " completed"}, 32'(done), 32'd1);
        check({tag, " latency"}, 32'(first_v_cyc - tlast_cyc), 32'd1);
        check({tag, " words"}, 32'(got.size()), 32'(n_exp));
        for (int i = 0; i < got.size() && i < n_exp; i++) begin
            check({tag, " word"}, 32'(got[i]), 32'({(i == n_exp - 1), words[i]}));
        end
        check({tag, " pkt_len"}, 32'(o_pkt_len), 32'(n_exp));
        check({tag, " overflow"}, 32'(o_overflow), 32'(model_ovf));
        check({tag, " max_count"}, 32'(max_cnt), 32'(n_exp));
        if (ready_mode == 0) begin
            check({tag, " drain"}, 32'(last_xfer_cyc - tlast_cyc), 32'(n_exp));
        end

        // Input side must reopen exactly two cycles after the last output transfer.
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 8 && !seen; k++) begin
                @(negedge i_clk);
                if (o_tready) seen = 1'b1;
                else begin
                    step();
                    cyc++;
                end
            end
            check({tag, " reopen"}, 32'(cyc - last_xfer_cyc), 32'd2);
            step();
        end

        n_got     = got.size();
        last_data = (got.size() > 0) ? got[got.size() - 1][7:0] : 8'h00;
    endtask

    task automatic check_post_reset(input string tag);
        @(negedge i_clk);
        check({tag, " empty"},    32'(o_empty),    32'd1);
        check({tag, " count"},    32'(o_count),    32'd0);
        check({tag, " valid"},    32'(o_valid),    32'd0);
        check({tag, " overflow"}, 32'(o_overflow), 32'd0);
        check({tag, " tready0"},  32'(o_tready),   32'd0);
        step();
        @(negedge i_clk);
        check({tag, " tready1"},  32'(o_tready),   32'd1);
        step();
    endtask

    typedef struct {
        string      name;
        int         len;
        logic [7:0] base;
        int         ready_mode;
        int         exp_len;
        bit         exp_ovf;
        logic [7:0] exp_last_data;
    } vec_t;

    initial begin
        vec_t       vecs[5];
        int         n_got;
        logic [7:0] last_data;

        vecs[0] = '{"nominal",   5, 8'h01, 0,  5, 1'b0, 8'h05};
        vecs[1] = '{"exact",    16, 8'h10, 0, 16, 1'b0, 8'h1F};
        vecs[2] = '{"single",    1, 8'hAA, 0,  1, 1'b0, 8'hAA};
        vecs[3] = '{"backpr",    3, 8'h30, 2,  3, 1'b0, 8'h32};
        vecs[4] = '{"truncate", 20, 8'h00, 0, 16, 1'b1, 8'h0F};

        // Reset state.
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst tready",   32'(o_tready),   32'd0);
        check("rst valid",    32'(o_valid),    32'd0);
        check("rst last",     32'(o_last),     32'd0);
        check("rst busy",     32'(o_busy),     32'd0);
        check("rst empty",    32'(o_empty),    32'd1);
        check("rst count",    32'(o_count),    32'd0);
        check("rst pkt_len",  32'(o_pkt_len),  32'd0);
        check("rst overflow", 32'(o_overflow), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("first cycle tready", 32'(o_tready), 32'd0);
        step();
        @(negedge i_clk);
        check("second cycle tready", 32'(o_tready), 32'd1);
        step();

        // Directed packet table.
        for (int v = 0; v < 5; v++) begin
            run_packet(vecs[v].name, vecs[v].len, vecs[v].base, 1'b0, vecs[v].ready_mode,
                       1'b0, n_got, last_data);
            check({vecs[v].name, " tbl_len"},  32'(o_pkt_len),  32'(vecs[v].exp_len));
            check({vecs[v].name, " tbl_ovf"},  32'(o_overflow), 32'(vecs[v].exp_ovf));
            check({vecs[v].name, " tbl_last"}, 32'(last_data),  32'(vecs[v].exp_last_data));
        end

        // Reset after 3 words of a packet (overflow is still set from truncation).
        for (int i = 0; i < 3; i++) begin
            i_tvalid = 1'b1;
            i_tdata  = 8'h50 + 8'(i);
            i_tlast  = 1'b0;
            step();
        end
        i_tvalid = 1'b0;
        @(negedge i_clk);
        check("mid-load count", 32'(o_count), 32'd3);
        step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        model_ovf = 1'b0;
        check_post_reset("rst-load");

        // Reset while a stored packet is waiting in s_SEND.
        for (int i = 0; i < 4; i++) begin
            i_tvalid = 1'b1;
            i_tdata  = 8'h60 + 8'(i);
            i_tlast  = (i == 3);
            i_ready  = 1'b0;
            step();
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        @(negedge i_clk);
        check("send before rst valid", 32'(o_valid), 32'd1);
        check("send before rst data",  32'(o_data),  32'h60);
        step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        check_post_reset("rst-send");

        run_packet("resume", 4, 8'h70, 1'b0, 0, 1'b0, n_got, last_data);

        // Randomized packets against the packet-level model.
        for (int p = 0; p < 14; p++) begin
            run_packet("random", $urandom_range(1, 22), 8'h00, 1'b1, 1, 1'b1, n_got, last_data);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/task_input_pkt_buffer.md
# task_input_pkt_buffer

Parametrised store-and-forward packet buffer for the task input path. Accepts one AXI-Stream-style packet at a time into an internal FIFO, truncates packets longer than the buffer, then replays the stored packet downstream with a valid/ready handshake and an end-of-packet marker. Sits between the task stream source and the task processing core. It replaces the fixed 8-bit, fire-and-forget input stage with configurable width and depth, output backpressure and overflow reporting.

## Interface
Parameters:
- DATA_W, 8, stream data width in bits (>=1)
- DEPTH, 16, FIFO depth in words; power of two, >=2
- CNT_W, $clog2(DEPTH+1), derived width of word counters (localparam)

Ports:
- Reset is i_rst, synchronous, active-high. Clock is i_clk.
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_tvalid  in  1  input word valid
- i_tdata  in  DATA_W  input word
- i_tlast  in  1  input word is last of packet
- o_tready  out  1  buffer accepts input word this cycle
- o_data  out  DATA_W  output word (FIFO head)
- o_valid  out  1  o_data/o_last valid
- o_last  out  1  output word is last of packet
- i_ready  in  1  downstream accepts output word
- o_busy  out  1  high in s_DISCARD and s_SEND
- o_empty  out  1  FIFO empty
- o_count  out  CNT_W  words currently in FIFO
- o_pkt_len  out  CNT_W  stored length of current/last packet
- o_overflow  out  1  sticky: a packet was truncated since reset

## Operation
- FIFO stores {last, data}, DATA_W+1 bits. First-word-fall-through: o_data = head word combinationally.
- Input transfer: i_tvalid && o_tready. Output transfer: o_valid && i_ready.
- States (enum): s_IDLE, s_LOAD, s_DISCARD, s_SEND.
- s_IDLE: o_tready=0. Go to s_LOAD next cycle unconditionally.
- s_LOAD: o_tready=1. Each transfer writes {i_tlast, i_tdata}.
  - On a transfer with i_tlast=1, go to s_SEND.
  - On a transfer with i_tlast=0 that fills the FIFO (count DEPTH-1 -> DEPTH), the word is written with last forced to 1. o_overflow is set and the state goes to s_DISCARD.
- s_DISCARD: o_tready=1. Input words are accepted and dropped. A transfer with i_tlast=1 moves the state to s_SEND.
- s_SEND: o_tready=0. o_valid = !o_empty. Each output transfer pops one word. The transfer with o_last=1 moves the state to s_IDLE.
- o_pkt_len is loaded with the FIFO count, including the final word, on entry to s_SEND. It holds until the next entry to s_SEND.
- Writes and reads never coincide, because o_tready=0 in s_SEND. Count changes by at most 1 per cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. Full is count==DEPTH and empty is count==0.

## Timing
- Reset values: state s_IDLE, pointers and count 0. Outputs: o_tready=0, o_valid=0, o_last=0, o_busy=0, o_empty=1, o_count=0, o_pkt_len=0, o_overflow=0. o_data is don't-care while o_valid=0.
- Reset mid-packet discards all stored words and clears o_overflow. It takes priority over all transfers in the same cycle.
- First o_tready=1 occurs in the 2nd cycle after i_rst deasserts (s_IDLE then s_LOAD).
- Latency: tlast accepted in cycle N -> s_SEND and o_valid=1 in cycle N+1 with the first word on o_data.
- With i_ready held high, a packet of L words drains in L cycles, N+1..N+L. The state is s_IDLE in N+L+1 and o_tready=1 in N+L+2.
- o_valid, o_data and o_last must hold stable while i_ready=0.
- o_count, o_empty and o_busy are registered or derived from registered state only. No combinational path runs from i_tvalid to o_tready.

## Structure
- Package task_input_pkg: the state enum typedef and the FIFO entry struct {last, data}. The struct is parametrised via the module, or kept as a width helper function.
- Sub-module task_input_sync_fifo: parametrised (WIDTH, DEPTH) single-clock FWFT FIFO. It provides wr_en/rd_en, dout, count, full and empty, with synchronous i_rst clearing pointers and count.
- The top level holds the FSM, forced-last logic, o_pkt_len and o_overflow.

## Test plan
- Nominal (DATA_W=8, DEPTH=16): packet 0x01..0x05 with tlast on 0x05, i_ready=1. Response: o_valid for 5 cycles starting the cycle after tlast, data 0x01..0x05, o_last only on 0x05, o_pkt_len=5, o_overflow=0.
- Exact fill: 16-word packet with tlast on word 16. Response: no overflow, o_count reaches 16, o_pkt_len=16, o_last on word 16.
- Truncation: 20-word packet 0x00..0x13. Response: words 0x00..0x0F output with o_last on 0x0F, o_overflow=1, o_tready=1 through word 0x13, s_SEND entered the cycle after word 0x13.
- Backpressure: 3-word packet, i_ready toggled 1,0,0,1,0,1. Response: o_data/o_last stable while i_ready=0, exactly 3 transfers, o_tready=0 until drain completes plus 2 cycles.
- Single-word packet: tlast on first word 0xAA. Response: one output 0xAA with o_last=1, o_pkt_len=1.
- Reset mid-operation: i_rst pulsed after 3 words of a packet and again during s_SEND. Response: next cycle o_empty=1, o_count=0, o_valid=0, o_overflow=0, o_tready=0. Normal capture resumes 2 cycles after i_rst deasserts.
